// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: programmable geometry, sync polarity and pixel-clock divider,
// with registered sync/bright/coordinate outputs and line/frame start strobes.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0,
   parameter int   CLK_DIV  = 2,
   parameter int   CW       = 10
) (
   input  logic          clock,
   input  logic          clear,
   input  logic          enable,
   output logic          pixTick,
   output logic          hSync,
   output logic          vSync,
   output logic          bright,
   output logic [CW-1:0] hCount,
   output logic [CW-1:0] vCount,
   output logic          lineStart,
   output logic          frameStart
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] hpos_q, hpos_d;
   logic [CW-1:0] vpos_q, vpos_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          bright_q, bright_d;
   logic [CW-1:0] hcount_q, hcount_d;
   logic [CW-1:0] vcount_q, vcount_d;
   logic          line_q, line_d;
   logic          frame_q, frame_d;
   logic          tick_s;
   logic          in_hsync_s;
   logic          in_vsync_s;
   logic          active_s;

   // Pixel divider and raster position advance
   always_comb begin
      tick_s = enable & clear & (div_q == DIV_LAST);
      div_d  = div_q;
      hpos_d = hpos_q;
      vpos_d = vpos_q;
      if (enable) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
         end else begin
            div_d = div_q + DW'(1);
         end
      end else begin
         div_d = div_q;
      end
      if (tick_s) begin
         if (hpos_q == H_LAST) begin
            hpos_d = '0;
            if (vpos_q == V_LAST) begin
               vpos_d = '0;
            end else begin
               vpos_d = vpos_q + CW'(1);
            end
         end else begin
            hpos_d = hpos_q + CW'(1);
         end
      end else begin
         hpos_d = hpos_q;
         vpos_d = vpos_q;
      end
   end

   // Decode of the pre-advance position, captured only on a pixel tick
   always_comb begin
      in_hsync_s = (hpos_q >= H_SS) && (hpos_q < H_SE);
      in_vsync_s = (vpos_q >= V_SS) && (vpos_q < V_SE);
      active_s   = (hpos_q < H_ACT) && (vpos_q < V_ACT);
      hsync_d    = hsync_q;
      vsync_d    = vsync_q;
      bright_d   = bright_q;
      hcount_d   = hcount_q;
      vcount_d   = vcount_q;
      line_d     = 1'b0;
      frame_d    = 1'b0;
      if (tick_s) begin
         hsync_d  = in_hsync_s ? H_POL : ~H_POL;
         vsync_d  = in_vsync_s ? V_POL : ~V_POL;
         bright_d = active_s;
         hcount_d = active_s ? hpos_q : '0;
         vcount_d = active_s ? vpos_q : '0;
         line_d   = (hpos_q == '0);
         frame_d  = (hpos_q == '0) && (vpos_q == '0);
      end else begin
         line_d  = 1'b0;
         frame_d = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         div_q    <= '0;
         hpos_q   <= '0;
         vpos_q   <= '0;
         hsync_q  <= ~H_POL;
         vsync_q  <= ~V_POL;
         bright_q <= 1'b0;
         hcount_q <= '0;
         vcount_q <= '0;
         line_q   <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         div_q    <= div_d;
         hpos_q   <= hpos_d;
         vpos_q   <= vpos_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         bright_q <= bright_d;
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         line_q   <= line_d;
         frame_q  <= frame_d;
      end
   end

   // Strobes are suppressed while paused so a frozen raster never repeats a pulse
   assign pixTick    = tick_s;
   assign hSync      = hsync_q;
   assign vSync      = vsync_q;
   assign bright     = bright_q;
   assign hCount     = hcount_q;
   assign vCount     = vcount_q;
   assign lineStart  = line_q & enable;
   assign frameStart = frame_q & enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster (15x8 pixels, divide-by-2,
// mixed sync polarities): checkpoint table, per-clock scoreboard model, pause and async clear.
module tb_vga_timing_gen;

   localparam int   HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int   VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int   HT = HA + HF + HS + HB;
   localparam int   VT = VA + VF + VS + VB;
   localparam int   CD = 2;
   localparam logic HPOL = 1'b0;
   localparam logic VPOL = 1'b1;
   localparam int   CW = 5;

   logic          clock;
   logic          clear;
   logic          enable;
   logic          pixTick, hSync, vSync, bright, lineStart, frameStart;
   logic [CW-1:0] hCount, vCount;
   logic [15:0]   dut_vec;
   logic [15:0]   got;

   int checks = 0;
   int errors = 0;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(HPOL), .V_POL(VPOL), .CLK_DIV(CD), .CW(CW)
   ) dut (
      .clock(clock), .clear(clear), .enable(enable),
      .pixTick(pixTick), .hSync(hSync), .vSync(vSync), .bright(bright),
      .hCount(hCount), .vCount(vCount),
      .lineStart(lineStart), .frameStart(frameStart)
   );

   assign dut_vec = {pixTick, hSync, vSync, bright, hCount, vCount, lineStart, frameStart};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [15:0] pack(input logic t, input logic hs, input logic vs,
                                        input logic br, input int hc, input int vc,
                                        input logic ls, input logic fs);
      return {t, hs, vs, br, 5'(hc), 5'(vc), ls, fs};
   endfunction

   task automatic chk(input string nm, input logic [15:0] g, input logic [15:0] x);
      checks++;
      if (g !== x) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, g, x, $time);
      end
   endtask

   task automatic chk_int(input string nm, input int g, input int x);
      checks++;
      if (g != x) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", nm, g, x, $time);
      end
   endtask

   // reference model: pixel index counter, decoded by div/mod
   int          m_div = 0;
   int          m_p = 0;
   logic        r_hs = ~HPOL, r_vs = ~VPOL, r_br = 1'b0, r_ls = 1'b0, r_fs = 1'b0;
   int          r_hc = 0, r_vc = 0;
   logic [15:0] sbq[$];

   task automatic model_step(input logic en, input logic clr);
      int  h, v;
      logic t;
      t = 1'b0;
      if (!clr) begin
         m_div = 0; m_p = 0;
         r_hs = ~HPOL; r_vs = ~VPOL; r_br = 1'b0; r_hc = 0; r_vc = 0; r_ls = 1'b0; r_fs = 1'b0;
      end else begin
         if (en && m_div == CD - 1) begin
            h    = m_p % HT;
            v    = m_p / HT;
            r_hs = (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL;
            r_vs = (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL;
            r_br = (h < HA) && (v < VA);
            r_hc = r_br ? h : 0;
            r_vc = r_br ? v : 0;
            r_ls = (h == 0);
            r_fs = (m_p == 0);
            m_p  = (m_p + 1) % (HT * VT);
         end else begin
            r_ls = 1'b0;
            r_fs = 1'b0;
         end
         if (en) m_div = (m_div + 1) % CD;
         t = en && (m_div == CD - 1);
      end
      sbq.push_back(pack(t, r_hs, r_vs, r_br, r_hc, r_vc, r_ls & en, r_fs & en));
   endtask

   task automatic step(input logic en, input logic clr);
      logic [15:0] x;
      enable = en;
      clear  = clr;
      model_step(en, clr);
      @(negedge clock);
      got = dut_vec;
      if (sbq.size() == 0) begin
         chk("sb_empty", got, ~got);
      end else begin
         x = sbq.pop_front();
         chk("sb", got, x);
      end
   endtask

   typedef struct {
      int          edge_n;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[15];

   initial begin
      int ti, prev_fs, prev_ls, n_fs, k;
      logic [15:0] held;
      logic found;

      tbl[0]  = '{0,   pack(0, 1, 0, 0, 0, 0, 0, 0)};
      tbl[1]  = '{1,   pack(1, 1, 0, 0, 0, 0, 0, 0)};
      tbl[2]  = '{2,   pack(0, 1, 0, 1, 0, 0, 1, 1)};
      tbl[3]  = '{3,   pack(1, 1, 0, 1, 0, 0, 0, 0)};
      tbl[4]  = '{16,  pack(0, 1, 0, 1, 7, 0, 0, 0)};
      tbl[5]  = '{18,  pack(0, 1, 0, 0, 0, 0, 0, 0)};
      tbl[6]  = '{22,  pack(0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[7]  = '{26,  pack(0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[8]  = '{28,  pack(0, 1, 0, 0, 0, 0, 0, 0)};
      tbl[9]  = '{32,  pack(0, 1, 0, 1, 0, 1, 1, 0)};
      tbl[10] = '{96,  pack(0, 1, 0, 1, 2, 3, 0, 0)};
      tbl[11] = '{158, pack(0, 1, 1, 0, 0, 0, 0, 0)};
      tbl[12] = '{210, pack(0, 1, 1, 0, 0, 0, 0, 0)};
      tbl[13] = '{212, pack(0, 1, 0, 0, 0, 0, 1, 0)};
      tbl[14] = '{242, pack(0, 1, 0, 1, 0, 0, 1, 1)};

      clear  = 1'b0;
      enable = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

      // release reset and walk the first two frames against the checkpoint table
      clear = 1'b1;
      #1;
      chk("vec_e0", dut_vec, tbl[0].exp);
      ti = 1; prev_fs = -1; prev_ls = -1; n_fs = 0;
      for (int e = 1; e <= 500; e++) begin
         step(1'b1, 1'b1);
         if (ti < 15 && tbl[ti].edge_n == e) begin
            chk($sformatf("vec_e%0d", e), got, tbl[ti].exp);
            ti++;
         end
         if (got[0]) begin
            if (prev_fs >= 0) chk_int("frame_period", e - prev_fs, HT * VT * CD);
            prev_fs = e;
            n_fs++;
         end
         if (got[1]) begin
            if (prev_ls >= 0) chk_int("line_period", e - prev_ls, HT * CD);
            prev_ls = e;
         end
      end
      chk_int("table_rows", ti, 15);
      chk_int("frame_pulses", n_fs, 3);

      // pause mid-line at hCount=5 for 37 clocks
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         step(1'b1, 1'b1);
         if (got[12] && got[11:7] == 5'd5) found = 1'b1;
      end
      chk_int("reach_h5", int'(found), 1);
      held = got;
      for (int i = 0; i < 37; i++) begin
         step(1'b0, 1'b1);
         chk("hold", got, held & 16'h7FFC);
      end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1'b1, 1'b1);
         if (got[11:7] != 5'd5) found = 1'b1;
      end
      chk_int("resume_hcount", int'(got[11:7]), 6);

      // random pauses under scoreboard
      for (int i = 0; i < 800; i++) step(($urandom_range(0, 3) != 0), 1'b1);

      // async clear mid-frame at (3,2)
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         step(1'b1, 1'b1);
         if (got[12] && got[11:7] == 5'd3 && got[6:2] == 5'd2) found = 1'b1;
      end
      chk_int("reach_3_2", int'(found), 1);
      #2 clear = 1'b0;
      #1 chk("async_clear", dut_vec, pack(0, 1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      k = 0;
      found = 1'b0;
      for (int i = 1; i <= 10 && !found; i++) begin
         step(1'b1, 1'b1);
         if (got[0]) begin
            found = 1'b1;
            k = i;
         end
      end
      chk_int("first_frame_after_clear", k, CD);
      for (int i = 0; i < 300; i++) step(1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; next generation of the fixed 640x480 controller.
- Produces hSync/vSync, bright, and active-area pixel coordinates for BitGen.
- Adds a programmable timing geometry, sync polarity, a pixel-clock divider from the board clock, a run-enable, and line/frame strobes for frame-buffer and sprite logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- H_POL, 0, asserted level of hSync (0 = active-low)
- V_POL, 0, asserted level of vSync
- CLK_DIV, 2, board clocks per pixel (1..16); 2 gives 25 MHz from 50 MHz
- CW, 10, width of the coordinate counters; must satisfy 2^CW > H_TOTAL and 2^CW > V_TOTAL

Ports:
- clock  in  1  board clock; all state changes on its rising edge
- clear  in  1  asynchronous, active-low reset
- enable  in  1  run; when low, all timing freezes in place
- pixTick  out  1  one-clock strobe; outputs below change only in the cycle after a pixTick
- hSync  out  1  horizontal sync, level set by H_POL
- vSync  out  1  vertical sync, level set by V_POL
- bright  out  1  high while the current pixel is in the active area
- hCount  out  CW  active-area column 0..H_ACTIVE-1; 0 outside the active area
- vCount  out  CW  active-area row 0..V_ACTIVE-1; 0 outside the active area
- lineStart  out  1  one-clock pulse when the pixel at hPos=0 is presented
- frameStart  out  1  one-clock pulse when the pixel at (0,0) is presented

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL defined the same way (525 at defaults).
- Internal position: hPos ranges 0..H_TOTAL-1 and vPos ranges 0..V_TOTAL-1. Each line is ordered active, front porch, sync, back porch.
- Divider: divCnt counts 0..CLK_DIV-1 while enable=1. pixTick=1 for the one cycle in which divCnt==CLK_DIV-1. For CLK_DIV=1, pixTick=enable.
- Position advance, on pixTick only:
  - hPos increments; at H_TOTAL-1 it wraps to 0 and vPos increments.
  - vPos wraps from V_TOTAL-1 to 0, simultaneously with the hPos wrap.
- Outputs are registered. On the clock edge where pixTick=1, the outputs take the decode of the pre-advance (hPos,vPos). Latency is therefore one clock from the tick, and outputs hold for CLK_DIV clocks.
- Decode rules:
  - hSync = H_POL when H_ACTIVE+H_FP <= hPos < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
  - vSync is decoded the same way on vPos using the V_* parameters. It changes at the line boundary, together with hPos=0.
  - bright = (hPos<H_ACTIVE) && (vPos<V_ACTIVE).
  - hCount = hPos and vCount = vPos when bright=1; otherwise both are 0.
  - lineStart = (hPos==0). frameStart = (hPos==0 && vPos==0). Each is high for exactly one clock.
- enable=0:
  - divCnt, hPos, vPos and all registered outputs hold.
  - pixTick, lineStart and frameStart are forced to 0.
  - Resuming continues from the held state, with no skipped or repeated pixel.
- Reset (clear=0, asynchronous, takes effect mid-line or mid-frame):
  - divCnt=0, hPos=0, vPos=0.
  - hSync=~H_POL, vSync=~V_POL.
  - bright=0, hCount=0, vCount=0, pixTick=0, lineStart=0, frameStart=0.
- After reset release, with enable=1, the first pixTick occurs CLK_DIV clocks later. frameStart follows on the next clock.
- Counter arithmetic: unsigned, CW bits. Wrap is by compare-to-total, never by natural overflow.

Test Plan:
- Defaults, enable=1 from reset: count clocks between frameStart pulses -> exactly 800*525*2 = 840000. Count clocks between lineStart pulses -> 1600.
- Defaults, one line: hSync low for 192 clocks, starting 1312 clocks after lineStart (656 pixels). bright high for 1280 clocks starting at lineStart. hCount ends at 639.
- Defaults, vertical: vSync low for exactly 2 lines, starting at line 490. bright=0 on lines 480..524. vCount max = 479.
- Small config H=4/1/1/1, V=3/1/1/1, CLK_DIV=1, H_POL=V_POL=1: hSync high only at hPos 5. Frame length = 42 clocks. hCount sequence per active line = 0,1,2,3,0,0,0.
- Deassert enable for 37 clocks mid-line at hCount=100: all outputs frozen, pixTick=0. After re-enable the next hCount is 101.
- Assert clear mid-frame at (300,200): outputs go to reset values immediately, without waiting for a clock edge. After release, frameStart pulses at clock CLK_DIV+1.
